// File: rtl/pipelined_shifter_if.sv
// ----------------------------------------------------------------------------
// pipelined_shifter_if
//   Handshake/data bundle for pipelined_shifter.
//   master : producer + consumer side (drives flush, in_*, out_ready)
//   slave  : the shifter itself (drives in_ready, out_valid, out_data, out_lost)
//   Signals:
//     flush            drop everything in flight
//     in_valid/ready   input handshake
//     in_data          operand, WIDTH bits
//     in_shamt         shift amount, LOG2W bits
//     in_mode          00 SLL, 01 SRL, 10 SRA, 11 ROTL
//     out_valid/ready  output handshake
//     out_data         result, WIDTH bits
//     out_lost         SLL/SRL only: a 1-bit was shifted out
// ----------------------------------------------------------------------------
interface pipelined_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int LOG2W = $clog2(WIDTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOG2W-1:0] in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_lost;

    modport master (
        output flush, in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_lost
    );

    modport slave (
        input  flush, in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_lost
    );
endinterface

// File: rtl/pipelined_shifter.sv
// ----------------------------------------------------------------------------
// pipelined_shifter
//   Fully pipelined barrel shifter (SLL/SRL/SRA/ROTL), one log2 step per
//   registered stage, valid/ready handshake with global stall and flush.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    pipelined_shifter_if.slave (flush, in_*, out_*)
//   Latency: LOG2W register edges counting the accept edge.
// ----------------------------------------------------------------------------

// One log2 step of the shift network: shifts by SH when en_i is set.
module pipelined_shifter_stage #(
    parameter int WIDTH = 32,
    parameter int SH    = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       mode_i,
    input  logic             en_i,
    input  logic             lost_i,
    output logic [WIDTH-1:0] data_o,
    output logic             lost_o
);
    always_comb begin
        data_o = data_i;
        lost_o = lost_i;
        if (en_i) begin
            case (mode_i)
                2'b00: begin
                    data_o = {data_i[WIDTH-SH-1:0], {SH{1'b0}}};
                    lost_o = lost_i | (|data_i[WIDTH-1:WIDTH-SH]);
                end
                2'b01: begin
                    data_o = {{SH{1'b0}}, data_i[WIDTH-1:SH]};
                    lost_o = lost_i | (|data_i[SH-1:0]);
                end
                // SRA: the MSB never changes, so copying the current MSB is
                // the original sign at every stage.
                2'b10:   data_o = {{SH{data_i[WIDTH-1]}}, data_i[WIDTH-1:SH]};
                default: data_o = {data_i[WIDTH-SH-1:0], data_i[WIDTH-1:WIDTH-SH]};
            endcase
        end
        // SRA and ROTL never lose information in the lost-flag sense.
        if (mode_i[1]) lost_o = 1'b0;
    end
endmodule

module pipelined_shifter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_shifter_if.slave bus
);
    localparam int LOG2W = $clog2(WIDTH);

    logic                        advance;
    logic [LOG2W-1:0]            vld_q;
    logic [LOG2W-1:0][WIDTH-1:0] data_q;
    logic [LOG2W-1:0]            lost_q;
    // The last stage has no consumer for its mode, so only LOG2W-1 are kept.
    logic [LOG2W-2:0][1:0]       mode_q;

    // Per-stage combinational inputs/outputs of the shift network.
    logic [LOG2W-1:0][WIDTH-1:0] stg_din, stg_dout;
    logic [LOG2W-1:0]            stg_lin, stg_lout;
    logic [LOG2W-1:0][1:0]       stg_mode;
    logic [LOG2W-1:0]            stg_en;

    // Global stall: everything moves only when the output slot is free.
    assign advance      = !vld_q[LOG2W-1] | bus.out_ready;
    assign bus.in_ready = advance & !bus.flush & rst_n;

    assign stg_din[0]  = bus.in_data;
    assign stg_lin[0]  = 1'b0;
    assign stg_mode[0] = bus.in_mode;
    assign stg_en[0]   = bus.in_shamt[0];

    for (genvar k = 1; k < LOG2W; k++) begin : g_link
        assign stg_din[k]  = data_q[k-1];
        assign stg_lin[k]  = lost_q[k-1];
        assign stg_mode[k] = mode_q[k-1];
    end

    // Remaining shift-amount bits travel with the data. Stage k keeps only
    // the bits not yet consumed, so the register narrows by one per stage
    // and its LSB is always the enable for the next stage.
    for (genvar k = 0; k < LOG2W-1; k++) begin : g_sh
        logic [LOG2W-k-2:0] sh_q;
        logic [LOG2W-k-2:0] sh_d;

        if (k == 0) begin : g_src
            assign sh_d = bus.in_shamt[LOG2W-1:1];
        end else begin : g_src
            assign sh_d = g_sh[k-1].sh_q[LOG2W-k-1:1];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sh_q <= '0;
            end else if (!bus.flush && advance) begin
                sh_q <= sh_d;
            end
        end

        assign stg_en[k+1] = sh_q[0];
    end

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        pipelined_shifter_stage #(
            .WIDTH (WIDTH),
            .SH    (1 << k)
        ) u_stage (
            .data_i (stg_din[k]),
            .mode_i (stg_mode[k]),
            .en_i   (stg_en[k]),
            .lost_i (stg_lin[k]),
            .data_o (stg_dout[k]),
            .lost_o (stg_lout[k])
        );
    end

    // Flush only kills valid bits; payload registers may hold stale values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
            lost_q <= '0;
            mode_q <= '0;
        end else if (bus.flush) begin
            vld_q  <= '0;
        end else if (advance) begin
            vld_q  <= {vld_q[LOG2W-2:0], bus.in_valid & bus.in_ready};
            data_q <= stg_dout;
            lost_q <= stg_lout;
            mode_q <= stg_mode[LOG2W-2:0];
        end
    end

    assign bus.out_valid = vld_q[LOG2W-1];
    assign bus.out_data  = data_q[LOG2W-1];
    assign bus.out_lost  = lost_q[LOG2W-1];
endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;
    typedef struct {
        logic [63:0] data;
        logic        lost;
        int          acc;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic rst_n;
    bit   lat;
    exp_t sb[$];
    exp_t me;

    pipelined_shifter_if #(.WIDTH(32)) bus ();
    pipelined_shifter #(.WIDTH(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Whole-word reference: shift as integer arithmetic on a wide value.
    function automatic logic [64:0] ref_shift(input logic [63:0] d, input int s,
                                              input logic [1:0] m, input int w);
        logic [127:0] x, msk;
        logic [63:0]  r;
        logic         lost;
        msk  = (128'd1 << w) - 128'd1;
        x    = {64'd0, d} & msk;
        lost = 1'b0;
        r    = '0;
        case (m)
            2'b00: begin
                r    = 64'((x << s) & msk);
                lost = ((x << s) >> w) != 128'd0;
            end
            2'b01: begin
                r    = 64'(x >> s);
                lost = (x & ((128'd1 << s) - 128'd1)) != 128'd0;
            end
            2'b10: begin
                if (x[w-1]) x = x | ~msk;
                r = 64'(($signed(x) >>> s) & msk);
            end
            default: r = 64'(((x << s) | (x >> (w - s))) & msk);
        endcase
        return {lost, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send_exp(input logic [31:0] d, input int s, input logic [1:0] m,
                            input logic [31:0] ed, input logic el);
        int   n = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = 5'(s);
        bus.in_mode  = m;
        do begin @(negedge clk); n++; end while (!bus.in_ready && n < 500);
        if (!bus.in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=in_ready_0 required=in_ready_1");
        end else begin
            e.data = 64'(ed); e.lost = el; e.acc = cyc + 1; e.chk_lat = lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rnd(input logic [63:0] d, input int s, input logic [1:0] m);
        logic [64:0] r;
        r = ref_shift(d, s, m, 32);
        send_exp(d[31:0], s, m, r[31:0], r[64]);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
        check("drain_pending", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output actual=%h required=none", bus.out_data);
            end else begin
                me = sb.pop_front();
                check("out_data", 64'(bus.out_data), me.data);
                check("out_lost", 64'(bus.out_lost), 64'(me.lost));
                if (me.chk_lat) check("latency", 64'(cyc), 64'(me.acc + 4));
            end
        end
    end

    // Independent random streams at other widths, each with its own reset.
    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        localparam int GW = (gi == 0) ? 8 : (gi == 1) ? 16 : 64;
        localparam int GL = $clog2(GW);

        logic g_rst = 1'b0;
        bit   started = 1'b0;
        bit   gdone = 1'b0;
        exp_t q[$];
        exp_t ge;

        pipelined_shifter_if #(.WIDTH(GW)) gbus ();
        pipelined_shifter #(.WIDTH(GW)) u_dut (.clk(clk), .rst_n(g_rst), .bus(gbus));

        always @(posedge clk) begin
            #1;
            gbus.out_ready = !started || ($urandom_range(0, 3) != 0);
        end

        initial begin : drv
            logic [63:0] d;
            int          s, n;
            logic [1:0]  m;
            logic [64:0] r;
            exp_t        e;
            gbus.flush = 1'b0; gbus.in_valid = 1'b0;
            gbus.in_data = '0; gbus.in_shamt = '0; gbus.in_mode = '0;
            repeat (2) @(posedge clk);
            #1 g_rst = 1'b1;
            for (int t = 0; t < 200; t++) begin
                if (t == 0) begin
                    d = (64'd1 << (GW - 1)) | 64'd1; s = GW - 1; m = 2'b11;
                    e.data = 64'd3 << (GW - 2); e.lost = 1'b0; e.chk_lat = 1'b1;
                end else begin
                    d = {$urandom(), $urandom()}; s = $urandom_range(0, GW - 1);
                    m = 2'($urandom_range(0, 3));
                    r = ref_shift(d, s, m, GW);
                    e.data = r[63:0]; e.lost = r[64]; e.chk_lat = 1'b0;
                end
                gbus.in_valid = 1'b1; gbus.in_data = GW'(d);
                gbus.in_shamt = GL'(s); gbus.in_mode = m;
                n = 0;
                do begin @(negedge clk); n++; end while (!gbus.in_ready && n < 500);
                if (!gbus.in_ready) begin
                    checks++; failures++;
                    $display("FAIL w%0d_send_timeout actual=in_ready_0 required=in_ready_1", GW);
                end else begin
                    e.acc = cyc + 1;
                    q.push_back(e);
                end
                @(posedge clk); #1;
                gbus.in_valid = 1'b0;
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
            n = 0;
            while (q.size() != 0 && n < 500) begin @(posedge clk); n++; end
            check($sformatf("w%0d_drain_pending", GW), 64'(q.size()), 64'd0);
            gdone = 1'b1;
        end

        always @(negedge clk) begin
            if (g_rst && gbus.out_valid && gbus.out_ready) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL w%0d_unexpected_output actual=%h required=none", GW, gbus.out_data);
                end else begin
                    ge = q.pop_front();
                    check($sformatf("w%0d_data", GW), 64'(gbus.out_data), ge.data);
                    check($sformatf("w%0d_lost", GW), 64'(gbus.out_lost), 64'(ge.lost));
                    if (ge.chk_lat) check($sformatf("w%0d_latency", GW), 64'(cyc), 64'(ge.acc + GL - 1));
                    started = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        bit rnd_done;
        rst_n = 1'b0; lat = 1'b0; rnd_done = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.in_shamt = '0; bus.in_mode = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_lost", 64'(bus.out_lost), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        // Known-answer modes, lost flag and shamt=0, each with latency check.
        lat = 1'b1;
        send_exp(32'h0000_0001, 31, 2'b00, 32'h8000_0000, 1'b0);
        send_exp(32'h8000_0000, 4,  2'b01, 32'h0800_0000, 1'b0);
        send_exp(32'h8000_0000, 4,  2'b10, 32'hF800_0000, 1'b0);
        send_exp(32'h8000_0001, 1,  2'b11, 32'h0000_0003, 1'b0);
        send_exp(32'h8000_0001, 1,  2'b00, 32'h0000_0002, 1'b1);
        send_exp(32'h0000_0003, 1,  2'b01, 32'h0000_0001, 1'b1);
        send_exp(32'hFFFF_FFFF, 31, 2'b10, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 4; i++) send_exp(32'hA5A5_0F0F, 0, 2'(i), 32'hA5A5_0F0F, 1'b0);
        drain();

        // Backpressure: 3-cycle output stall at the first result.
        lat = 1'b0;
        fork
            for (int i = 1; i <= 8; i++) send_exp(32'(i), 1, 2'b00, 32'(2 * i), 1'b0);
            begin
                int k;
                k = 0;
                do begin @(posedge clk); #1; k++; end while (!bus.out_valid && k < 100);
                bus.out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_out_data", 64'(bus.out_data), 64'd2);
                end
                @(posedge clk); #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Flush three in-flight transactions, then accept one right after.
        send_rnd(64'h11, 3, 2'b00);
        send_rnd(64'h22, 3, 2'b01);
        send_rnd(64'h33, 3, 2'b11);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        sb.delete();
        lat = 1'b1;
        fork
            send_exp(32'h1234_5678, 8, 2'b00, 32'h3456_7800, 1'b1);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("post_flush_out_valid", 64'(bus.out_valid), 64'd0);
            end
        join
        lat = 1'b0;
        drain();

        // Reset while a result is stalled at the output.
        bus.out_ready = 1'b0;
        send_exp(32'h8000_0001, 1, 2'b00, 32'h0000_0002, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        check("pre_rst_out_lost", 64'(bus.out_lost), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_data", 64'(bus.out_data), 64'd0);
        check("midrst_out_lost", 64'(bus.out_lost), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1 bus.out_ready = 1'b1;

        // Random stream with random output backpressure.
        fork
            begin
                for (int t = 0; t < 300; t++) begin
                    send_rnd({$urandom(), $urandom()}, $urandom_range(0, 31), 2'($urandom_range(0, 3)));
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        n = 0;
        while (!(g_w[0].gdone && g_w[1].gdone && g_w[2].gdone) && n < 20000) begin
            @(posedge clk); n++;
        end
        check("width_sweep_done", 64'(g_w[0].gdone && g_w[1].gdone && g_w[2].gdone), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
